// File: rtl/bch_trap_decoder_if.sv
// Handshake bundle for the bit-serial error-trapping BCH decoder:
// serial bit input on one side, decoded message output on the other.
interface bch_trap_decoder_if #(
  parameter int K  = 7,
  parameter int CW = 4
);
  logic          in_valid;
  logic          in_ready;
  logic          in_bit;
  logic          out_valid;
  logic          out_ready;
  logic [K-1:0]  out_data;
  logic          out_err;
  logic [CW-1:0] out_nerr;

  modport master (
    output in_valid, in_bit, out_ready,
    input  in_ready, out_valid, out_data, out_err, out_nerr
  );

  modport slave (
    input  in_valid, in_bit, out_ready,
    output in_ready, out_valid, out_data, out_err, out_nerr
  );
endinterface

// File: rtl/bch_trap_decoder.sv
// Bit-serial error-trapping decoder for binary cyclic/BCH codes: loads N bits while
// dividing by g(x), then rotates the word N times, correcting once the syndrome weight is <= T.
module bch_trap_decoder #(
  parameter int            N     = 15,
  parameter int            K     = 7,
  parameter int            T     = 2,
  parameter logic [N-K:0]  GPOLY = 9'h1D1,
  parameter int            CW    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  bch_trap_decoder_if.slave bus,
  output logic              busy
);

  localparam int R    = N - K;
  localparam int CNTW = $clog2(N + 1);
  localparam logic [R-1:0]    GLOW = GPOLY[R-1:0];
  localparam logic [CNTW-1:0] LAST = CNTW'(N - 1);

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_TRAP = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [R-1:0]    s_q, s_d;
  logic [N-1:0]    cw_q, cw_d;
  logic            trapped_q, trapped_d;
  logic [CW-1:0]   nerr_q, nerr_d;
  logic [K-1:0]    out_data_q, out_data_d;
  logic            out_err_q, out_err_d;
  logic [CW-1:0]   out_nerr_q, out_nerr_d;

  logic            in_ready_c;
  logic            out_valid_c;
  logic            busy_c;
  logic [CW-1:0]   s_weight;
  logic [N-1:0]    cw_fix;
  logic [R-1:0]    s_fix;

  always_comb begin
    s_weight = '0;
    for (int i = 0; i < R; i++) begin
      s_weight = s_weight + CW'(s_q[i]);
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    s_d        = s_q;
    cw_d       = cw_q;
    trapped_d  = trapped_q;
    nerr_d     = nerr_q;
    out_data_d = out_data_q;
    out_err_d  = out_err_q;
    out_nerr_d = out_nerr_q;
    in_ready_c = 1'b0;
    out_valid_c = 1'b0;
    busy_c     = 1'b0;
    cw_fix     = cw_q;
    s_fix      = s_q;

    case (state_q)
      ST_LOAD: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          // Shift-register division: s tracks the received prefix mod g(x).
          cw_d = {cw_q[N-2:0], bus.in_bit};
          s_d  = {s_q[R-2:0], bus.in_bit} ^ (s_q[R-1] ? GLOW : '0);
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = ST_TRAP;
          end else begin
            cnt_d = cnt_q + CNTW'(1);
          end
        end
      end

      ST_TRAP: begin
        busy_c = 1'b1;
        if (!trapped_q && (s_weight <= CW'(T))) begin
          cw_fix    = cw_q ^ {{K{1'b0}}, s_q};
          s_fix     = '0;
          trapped_d = 1'b1;
          nerr_d    = s_weight;
        end
        // Rotation keeps s equal to (rotated word) mod g(x).
        cw_d = {cw_fix[N-2:0], cw_fix[N-1]};
        s_d  = {s_fix[R-2:0], 1'b0} ^ (s_fix[R-1] ? GLOW : '0);
        if (cnt_q == LAST) begin
          cnt_d      = '0;
          state_d    = ST_OUT;
          out_data_d = cw_d[N-1:N-K];
          out_err_d  = ~trapped_d;
          out_nerr_d = trapped_d ? nerr_d : '0;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end

      ST_OUT: begin
        busy_c      = 1'b1;
        out_valid_c = 1'b1;
        if (bus.out_ready) begin
          state_d   = ST_LOAD;
          cnt_d     = '0;
          s_d       = '0;
          cw_d      = '0;
          trapped_d = 1'b0;
          nerr_d    = '0;
        end
      end

      default: begin
        state_d = ST_LOAD;
      end
    endcase

    // Abort wins over any bit or output handshake in the same cycle.
    if (flush) begin
      state_d   = ST_LOAD;
      cnt_d     = '0;
      s_d       = '0;
      cw_d      = '0;
      trapped_d = 1'b0;
      nerr_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_LOAD;
      cnt_q      <= '0;
      s_q        <= '0;
      cw_q       <= '0;
      trapped_q  <= 1'b0;
      nerr_q     <= '0;
      out_data_q <= '0;
      out_err_q  <= 1'b0;
      out_nerr_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      s_q        <= s_d;
      cw_q       <= cw_d;
      trapped_q  <= trapped_d;
      nerr_q     <= nerr_d;
      out_data_q <= out_data_d;
      out_err_q  <= out_err_d;
      out_nerr_q <= out_nerr_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_data  = out_data_q;
  assign bus.out_err   = out_err_q;
  assign bus.out_nerr  = out_nerr_q;
  assign busy          = busy_c;

endmodule

// File: tb/tb_bch_trap_decoder.sv
// Bench for bch_trap_decoder: directed and randomized words checked against a
// polynomial-arithmetic model of error trapping (long division and whole-word rotation).
module tb_bch_trap_decoder;

  localparam int N = 15;
  localparam int K = 7;
  localparam int T = 2;
  localparam int R = N - K;
  localparam int CW = 4;
  localparam logic [R:0] G = 9'h1D1;

  typedef struct packed {
    logic [K-1:0]  data;
    logic          err;
    logic [CW-1:0] nerr;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  logic busy;
  int   tests = 0;
  int   failed = 0;
  exp_t exp_q[$];

  bch_trap_decoder_if #(.K(K), .CW(CW)) ifc();

  bch_trap_decoder #(.N(N), .K(K), .T(T), .GPOLY(G), .CW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (ifc.slave),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  // Remainder of a(x) divided by g(x), by schoolbook long division.
  function automatic logic [R-1:0] pmod(input logic [N-1:0] a);
    logic [N-1:0] x;
    logic [N-1:0] gw;
    x  = a;
    gw = N'(G);
    for (int b = N - 1; b >= R; b--) begin
      if (x[b]) x = x ^ (gw << (b - R));
    end
    return x[R-1:0];
  endfunction

  function automatic logic [N-1:0] rotl(input logic [N-1:0] a, input int i);
    return (i == 0) ? a : ((a << i) | (a >> (N - i)));
  endfunction

  function automatic logic [N-1:0] rotr(input logic [N-1:0] a, input int i);
    return (i == 0) ? a : ((a >> i) | (a << (N - i)));
  endfunction

  function automatic logic [N-1:0] encode(input logic [K-1:0] msg);
    logic [N-1:0] a;
    a = {msg, {R{1'b0}}};
    return a | N'(pmod(a));
  endfunction

  // First cyclic shift whose syndrome is light enough locates the error burst.
  function automatic exp_t model(input logic [N-1:0] r);
    exp_t e;
    logic [R-1:0] syn;
    logic [N-1:0] corr;
    int w;
    e.data = r[N-1:R];
    e.err  = 1'b1;
    e.nerr = '0;
    for (int i = 0; i < N; i++) begin
      syn = pmod(rotl(r, i));
      w   = $countones(syn);
      if (w <= T) begin
        corr   = r ^ rotr(N'(syn), i);
        e.data = corr[N-1:R];
        e.err  = 1'b0;
        e.nerr = CW'(w);
        break;
      end
    end
    return e;
  endfunction

  // Compare process: every cycle out_valid is high the outputs must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && ifc.out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 32'(ifc.out_valid), 32'd0);
      end else begin
        check("model_word", 32'({ifc.out_data, ifc.out_err, ifc.out_nerr}), 32'(exp_q[0]));
        if (ifc.out_ready && !flush) begin
          $display("[TB] word data=%h err=%b nerr=%0d", ifc.out_data, ifc.out_err, ifc.out_nerr);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Streams a word MSB first; gap_pct is the chance of idling in_valid on a cycle.
  task automatic send_word(input logic [N-1:0] w, input int gap_pct);
    int idx;
    int guard;
    bit acc;
    idx   = N - 1;
    guard = 0;
    while (idx >= 0 && guard < 2000) begin
      if ($urandom_range(99) < gap_pct) begin
        ifc.in_valid = 1'b0;
        ifc.in_bit   = 1'($urandom);
      end else begin
        ifc.in_valid = 1'b1;
        ifc.in_bit   = w[idx];
      end
      acc = ifc.in_valid && ifc.in_ready;
      tick();
      if (acc) idx--;
      guard++;
    end
    ifc.in_valid = 1'b0;
    if (idx >= 0) check("send_timeout", 32'(idx), 32'hFFFF_FFFF);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic run_word(input logic [N-1:0] w, input int gap, input bit lit,
                          input exp_t lit_exp, input bit chk_lat, input string name);
    int lat;
    send_word(w, gap);
    exp_q.push_back(model(w));
    lat = 0;
    while (!ifc.out_valid && lat < 200) begin
      tick();
      lat++;
    end
    if (chk_lat) check({name, "_latency"}, 32'(lat), 32'(N));
    if (!ifc.out_valid) check({name, "_timeout"}, 32'(ifc.out_valid), 32'd1);
    else if (lit) check(name, 32'({ifc.out_data, ifc.out_err, ifc.out_nerr}), 32'(lit_exp));
    drain();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] w;
    logic [N-1:0] e;
    logic [K-1:0] snap_data;
    bit stable;
    int wt;

    rst_n = 1'b0;
    flush = 1'b0;
    ifc.in_valid  = 1'b0;
    ifc.in_bit    = 1'b0;
    ifc.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(ifc.in_ready), 32'd1);
    check("rst_out_valid", 32'(ifc.out_valid), 32'd0);
    check("rst_outputs", 32'({ifc.out_data, ifc.out_err, ifc.out_nerr}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;

    // Hand-derived values that pin the model.
    check("model_clean", 32'(model(15'h40E8)), 32'({7'h40, 1'b0, 4'd0}));
    check("model_single", 32'(model(15'h00E8)), 32'({7'h40, 1'b0, 4'd1}));
    check("model_double", 32'(model(15'h00E9)), 32'({7'h40, 1'b0, 4'd2}));
    check("model_encode", 32'(encode(7'h01)), 32'h01D1);

    tick();
    run_word(15'h40E8, 0, 1'b1, {7'h40, 1'b0, 4'd0}, 1'b1, "clean");
    run_word(15'h00E8, 0, 1'b1, {7'h40, 1'b0, 4'd1}, 1'b1, "single");
    run_word(15'h00E9, 0, 1'b1, {7'h40, 1'b0, 4'd2}, 1'b1, "double");

    for (int i = 0; i < N; i++) begin
      w = 15'h40E8 ^ (N'(1) << i);
      run_word(w, 0, 1'b1, {7'h40, 1'b0, 4'd1}, 1'b0, "sweep1");
    end
    for (int i = 0; i < N; i++) begin
      for (int j = i + 1; j < N; j++) begin
        w = 15'h01D1 ^ (N'(1) << i) ^ (N'(1) << j);
        run_word(w, 0, 1'b1, {7'h01, 1'b0, 4'd2}, 1'b0, "sweep2");
      end
    end

    run_word(15'h0421, 0, 1'b0, '0, 1'b1, "triple");
    run_word(15'h0421, 40, 1'b0, '0, 1'b1, "triple_gaps");

    // Back-pressure: outputs held and input blocked while the sink stalls.
    ifc.out_ready = 1'b0;
    send_word(15'h40E8, 0);
    exp_q.push_back(model(15'h40E8));
    repeat (N) tick();
    check("bp_valid", 32'(ifc.out_valid), 32'd1);
    snap_data = ifc.out_data;
    stable = 1'b1;
    repeat (20) begin
      tick();
      if (!ifc.out_valid || ifc.out_data !== snap_data || ifc.in_ready !== 1'b0) stable = 1'b0;
    end
    check("bp_stable", 32'(stable), 32'd1);
    check("bp_data", 32'(ifc.out_data), 32'h40);
    ifc.out_ready = 1'b1;
    tick();
    check("bp_release_in_ready", 32'(ifc.in_ready), 32'd1);
    check("bp_release_out_valid", 32'(ifc.out_valid), 32'd0);
    run_word(encode(7'h2A), 0, 1'b1, {7'h2A, 1'b0, 4'd0}, 1'b1, "b2b_a");
    run_word(encode(7'h55) ^ 15'h0003, 0, 1'b1, {7'h55, 1'b0, 4'd2}, 1'b1, "b2b_b");

    // Flush after 9 bits, then a clean word must decode from scratch.
    for (int i = 0; i < 9; i++) begin
      ifc.in_valid = 1'b1;
      ifc.in_bit   = 1'($urandom);
      tick();
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    ifc.in_valid = 1'b0;
    check("flush_in_ready", 32'(ifc.in_ready), 32'd1);
    check("flush_busy", 32'(busy), 32'd0);
    run_word(15'h01D1, 0, 1'b1, {7'h01, 1'b0, 4'd0}, 1'b1, "after_flush");

    // Flush mid-TRAP: no word may appear.
    send_word(15'h40E8, 0);
    repeat (4) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (N + 3) tick();
    check("flush_trap_valid", 32'(ifc.out_valid), 32'd0);
    check("flush_trap_busy", 32'(busy), 32'd0);

    // Asynchronous reset mid-TRAP.
    send_word(15'h00E8, 0);
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    check("rst_trap_in_ready", 32'(ifc.in_ready), 32'd1);
    check("rst_trap_out_valid", 32'(ifc.out_valid), 32'd0);
    check("rst_trap_busy", 32'(busy), 32'd0);
    tick();
    rst_n = 1'b1;
    run_word(15'h01D1, 0, 1'b1, {7'h01, 1'b0, 4'd0}, 1'b1, "after_reset");

    // Randomized words with up to T+1 errors and random input gaps.
    for (int n = 0; n < 40; n++) begin
      e  = '0;
      wt = $urandom_range(0, T + 1);
      for (int b = 0; b < wt; b++) e[$urandom_range(N - 1)] = 1'b1;
      w = encode(K'($urandom)) ^ e;
      run_word(w, $urandom_range(0, 50), 1'b0, '0, 1'b1, "random");
    end

    drain();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
